uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 and 2.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only when UART_TX_PARITY_EN is defined.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 baud_tick  input  1  one-clk-wide pulse, one per bit period, from the baud rate generator.
REQ-007 tx_valid  input  1  tx_data holds a byte to send.
REQ-008 tx_data  input  DATA_BITS  frame payload.
REQ-009 tx_ready  output  1  block accepts a new frame this cycle.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 tx_busy  output  1  frame in progress.
REQ-012 tx_done  output  1  one-clk pulse at frame completion.

Function
REQ-013 States SHALL be IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-014 tx_ready SHALL be high only in IDLE; tx_busy SHALL equal NOT IDLE.
REQ-015 Accept SHALL occur on a clk edge with tx_valid and tx_ready both high: tx_data is latched into a shift register and the FSM moves to SYNC.
REQ-016 A baud_tick in the accept cycle SHALL be ignored; SYNC SHALL wait for the next baud_tick, so each bit lasts exactly one tick interval.
REQ-017 SYNC: on baud_tick, tx SHALL go 0 and the FSM SHALL move to START.
REQ-018 START: on baud_tick, tx SHALL take data bit 0 (LSB first) and the FSM SHALL move to DATA with bit counter 0.
REQ-019 DATA: on each baud_tick, the counter SHALL increment and tx SHALL take the next bit; after bit DATA_BITS-1 has been held one interval, the FSM SHALL go to PARITY (if enabled), else to STOP with tx=1.
REQ-020 PARITY: on entry tx SHALL equal the XOR of the latched data (even) or its inverse (odd); on the next baud_tick tx SHALL go 1 and the FSM SHALL move to STOP.
REQ-021 STOP: tx SHALL be held 1 for STOP_BITS tick intervals; on the tick ending the last one, the FSM SHALL return to IDLE and tx_done SHALL pulse for exactly one clk.
REQ-022 tx, tx_ready and tx_busy SHALL be registered outputs with no combinational path from inputs.
REQ-023 tx_valid while busy SHALL be ignored; the latched data SHALL NOT change mid-frame.
REQ-024 Back-to-back frames: tx_valid held high SHALL be accepted in the clk after tx_done, going to SYNC; the stop bit is never shortened.
REQ-025 Without baud_tick, the FSM SHALL hold its state and tx level indefinitely.
REQ-026 The bit counter SHALL be $clog2(DATA_BITS) bits wide (minimum 1) and SHALL NOT wrap within a frame.

Reset
REQ-027 rst high SHALL immediately force IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, and clear the shift register and counters.
REQ-028 rst asserted mid-frame SHALL abandon the frame with no tx_done; after release, tx stays 1 until a new accept.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL exist and frames SHALL carry 1 parity bit, giving 1+DATA_BITS+1+STOP_BITS bits.
REQ-030 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, frames SHALL be 1+DATA_BITS+STOP_BITS bits, and PARITY_ODD has no effect.

Verification
REQ-031 Defaults, baud_tick every 4 clks, send 8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clks; one tx_done pulse.
REQ-032 Parity enabled, even, send 8'h07 -> parity bit 1; PARITY_ODD=1, same data -> parity bit 0.
REQ-033 tx_valid asserted in the same cycle as baud_tick while IDLE -> start bit begins at the following tick, not at that one.
REQ-034 tx_valid held high with 8'h55 then 8'hAA, STOP_BITS=2 -> two complete frames, each stop period 8 clks, no gap shorter than 2 bit periods.
REQ-035 rst pulsed during DATA bit 3 -> tx=1 and tx_ready=1 in the same cycle, no tx_done, next frame correct.
REQ-036 tx_data changed and tx_valid pulsed mid-frame -> transmitted bits unchanged, no second accept.

Source files
------------

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial transmitter. Frame: 1 start bit, DATA_BITS data bits
// sent LSB first, an optional parity bit, then STOP_BITS stop bits.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit follows the data bits
//                      (even parity, or odd when PARITY_ODD=1). When it is
//                      undefined, the PARITY state does not exist and
//                      PARITY_ODD has no effect.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   STOP_BITS   stop bits per frame (1 or 2)
//   PARITY_ODD  0 = even parity, 1 = odd parity
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   baud_tick  one-clk pulse per bit period from the baud rate generator
//   tx_valid   tx_data holds a frame payload to send
//   tx_data    frame payload (DATA_BITS)
//   tx_ready   high only while idle; accept happens on tx_valid & tx_ready
//   tx         serial line, idle high (registered)
//   tx_busy    frame in progress (registered)
//   tx_done    one-clk pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  // Elaboration-time guards on the legal parameter ranges.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] data_reg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;

  // tx/tx_ready/tx_busy are loaded together with every state change so
  // they always match the registered state, with no input-to-output path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_reg <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          // A baud_tick coinciding with the accept is deliberately ignored:
          // SYNC waits for the next tick so the start bit is a full period.
          if (tx_valid) begin
            data_reg <= tx_data;
            state    <= SYNC;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end

        SYNC: begin
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (baud_tick) begin
            tx      <= data_reg[0];
            bit_cnt <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= (^data_reg) ^ 1'(PARITY_ODD);
              state <= PARITY;
`else
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              // bit_cnt stops at LAST_BIT, so it never wraps within a frame.
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= data_reg[bit_cnt + 1'b1];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
`endif

        STOP: begin
          if (baud_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
